i2s_slave_tx: RTL and testbench

- I2S transmitter in slave mode: serialises stereo samples onto sd_out, timed by an external sclk and ws that this block does not generate.
- Used where the codec or another board is bit-clock master, e.g. playback of loaded tracks.
- Samples arrive on a single-entry valid/ready stream in the clk domain.
- sclk_in and ws_in are oversampled in the clk domain, so clk must be at least 8x sclk.

---
 rtl/i2s_slave_tx.sv | 176 +++++++++++++++++
 tb/tb_i2s_slave_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slave_tx
// Brief    : I2S slave transmitter; serialises stereo pairs on external sclk/ws.
//            Optional I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN: repeat last pair on underrun.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_slave_tx #(
  parameter int WIDTH          = 8,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk_in,
  input  logic                      ws_in,
  input  logic [WIDTH-1:0]          s_data_l,
  input  logic [WIDTH-1:0]          s_data_r,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      sd_out,
  output logic                      frame_start,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_WIDTH = c_CNT_W'(WIDTH);

  logic [1:0]                sclk_sync_q;
  logic                      sclk_dly_q;
  logic [1:0]                ws_sync_q;
  logic                      ws_prev_q, ws_prev_d;
  logic                      primed_q, primed_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]          hold_l_q, hold_l_d;
  logic [WIDTH-1:0]          hold_r_q, hold_r_d;
  logic [WIDTH-1:0]          shreg_q, shreg_d;
  logic [WIDTH-1:0]          frame_r_q, frame_r_d;
  logic [c_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                      sd_out_q, sd_out_d;
  logic                      frame_start_q, frame_start_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
  logic [WIDTH-1:0]          last_l_q, last_l_d;
  logic [WIDTH-1:0]          last_r_q, last_r_d;
`endif

  logic w_sclk_fall;
  logic w_ws;
  logic w_accept;

  // ws is taken from the same sync stage as sclk so both see an edge together
  assign w_sclk_fall = sclk_dly_q & ~sclk_sync_q[1];
  assign w_ws        = ws_sync_q[1];
  assign w_accept    = s_valid & ~hold_valid_q;

  assign s_ready        = ~hold_valid_q;
  assign sd_out         = sd_out_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

  always_comb begin
    ws_prev_d     = ws_prev_q;
    primed_d      = primed_q;
    hold_valid_d  = hold_valid_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    shreg_d       = shreg_q;
    frame_r_d     = frame_r_q;
    bit_cnt_d     = bit_cnt_q;
    sd_out_d      = sd_out_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ucnt_d        = ucnt_q;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
`endif

    if (w_sclk_fall) begin
      ws_prev_d = w_ws;
      primed_d  = 1'b1;
      if (primed_q && (w_ws != ws_prev_q)) begin
        // Word boundary: sd_out holds for one bit (I2S one-bit delay)
        bit_cnt_d = '0;
        if (!w_ws) begin
          frame_start_d = 1'b1;
          if (hold_valid_q) begin
            shreg_d      = hold_l_q;
            frame_r_d    = hold_r_q;
            hold_valid_d = 1'b0;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
            last_l_d     = hold_l_q;
            last_r_d     = hold_r_q;
`endif
          end else begin
            underrun_d = 1'b1;
            if (ucnt_q != '1) begin
              ucnt_d = ucnt_q + 1'b1;
            end
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
            shreg_d   = last_l_q;
            frame_r_d = last_r_q;
`else
            shreg_d   = '0;
            frame_r_d = '0;
`endif
          end
        end else begin
          shreg_d = frame_r_q;
        end
      end else if (bit_cnt_q < c_WIDTH) begin
        sd_out_d  = shreg_q[WIDTH-1];
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        sd_out_d = 1'b0;
      end
    end

    // Only possible while the buffer is empty, so never collides with a consume
    if (w_accept) begin
      hold_l_d     = s_data_l;
      hold_r_d     = s_data_r;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      sclk_dly_q    <= 1'b0;
      ws_sync_q     <= '0;
      ws_prev_q     <= 1'b0;
      primed_q      <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shreg_q       <= '0;
      frame_r_q     <= '0;
      bit_cnt_q     <= c_WIDTH;
      sd_out_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= '0;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q      <= '0;
      last_r_q      <= '0;
`endif
    end else begin
      sclk_sync_q   <= {sclk_sync_q[0], sclk_in};
      sclk_dly_q    <= sclk_sync_q[1];
      ws_sync_q     <= {ws_sync_q[0], ws_in};
      ws_prev_q     <= ws_prev_d;
      primed_q      <= primed_d;
      hold_valid_q  <= hold_valid_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shreg_q       <= shreg_d;
      frame_r_q     <= frame_r_d;
      bit_cnt_q     <= bit_cnt_d;
      sd_out_q      <= sd_out_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_slave_tx
// Brief    : Scoreboard bench for i2s_slave_tx; bench acts as sclk/ws master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_slave_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

`ifdef I2S_SLAVE_TX_REPEAT_ON_UNDERRUN_EN
  localparam logic [7:0] c_UR1_L = 8'h81, c_UR1_R = 8'h7E;
  localparam logic [7:0] c_UR2_L = 8'hF0, c_UR2_R = 8'h0F;
`else
  localparam logic [7:0] c_UR1_L = 8'h00, c_UR1_R = 8'h00;
  localparam logic [7:0] c_UR2_L = 8'h00, c_UR2_R = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sclk_in;
  logic             ws_in;
  logic [WIDTH-1:0] s_data_l;
  logic [WIDTH-1:0] s_data_r;
  logic             s_valid;
  logic             s_ready;
  logic             sd_out;
  logic             frame_start;
  logic             underrun;
  logic [CNT_W-1:0] underrun_count;

  int pos;
  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int uf_cnt = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               left;
    int               fs;
    int               uf;
    int               cnt;
  } exp_t;
  exp_t exp_q[$];

  i2s_slave_tx #(.WIDTH(WIDTH), .UNDERRUN_CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .sclk_in        (sclk_in),
    .ws_in          (ws_in),
    .s_data_l       (s_data_l),
    .s_data_r       (s_data_r),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .sd_out         (sd_out),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  // Bit-clock master: sclk = clk/16, 64 sclk per frame, ws changes on sclk fall
  initial begin
    sclk_in = 1'b0;
    ws_in   = 1'b1;
    pos     = 63;
    forever begin
      repeat (8) @(posedge clk);
      #1 sclk_in = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      pos     = (pos + 1) % 64;
      ws_in   = (pos >= 32);
      sclk_in = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (underrun)    uf_cnt <= uf_cnt + 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge sclk_in);
      n++;
    end while (pos != p && n < 200);
    if (pos != p) check("wait_pos_timeout", pos, p);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 4096) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    s_data_l = l;
    s_data_r = r;
    s_valid  = 1'b1;
    wait_ready();
    s_valid  = 1'b0;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                          input int fs, input int uf, input int cnt);
    exp_t e;
    e.data = l; e.left = 1'b1; e.fs = fs; e.uf = uf; e.cnt = cnt;
    exp_q.push_back(e);
    e.data = r; e.left = 1'b0;
    exp_q.push_back(e);
  endtask

  // Called mid right slot: optionally loads a pair, then books the next frame
  task automatic frame(input bit push, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                       input logic [WIDTH-1:0] el, input logic [WIDTH-1:0] er,
                       input int uf, input int cnt);
    wait_pos(40);
    if (push) send_pair(l, r);
    push_exp(el, er, 1, uf, cnt);
  endtask

  // Monitor: assembles each slot from sd_out and scores it against the queue
  initial begin : monitor
    logic [WIDTH-1:0] bits;
    bit               padnz;
    bit               active;
    int               p, fs0, uf0;
    exp_t             e;
    bits = '0; padnz = 1'b0; active = 1'b0; fs0 = 0; uf0 = 0;
    forever begin
      @(negedge sclk_in);
      p = pos;
      if (p == 0) begin
        active = (exp_q.size() != 0);
        fs0    = fs_cnt;
        uf0    = uf_cnt;
      end
      repeat (4) @(posedge clk);
      #1;
      if (p % 32 == 0) begin
        bits  = '0;
        padnz = 1'b0;
      end else if (p % 32 <= WIDTH) begin
        bits = {bits[WIDTH-2:0], sd_out};
      end else begin
        padnz = padnz | sd_out;
      end
      if (active && (p == 31 || p == 63) && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.left ? "left_word" : "right_word", bits, e.data);
        check("slot_padding", padnz, 0);
        if (e.left) begin
          check("frame_start_pulses", fs_cnt - fs0, e.fs);
          check("underrun_pulses", uf_cnt - uf0, e.uf);
          check("underrun_count", underrun_count, e.cnt);
        end
      end
    end
  end

  logic [7:0] pl [4];
  logic [7:0] pr [4];

  initial begin : stimulus
    int n;
    pl = '{8'h11, 8'h22, 8'h4B, 8'hF0};
    pr = '{8'hEE, 8'hDD, 8'hB4, 8'h0F};
    rst = 1'b1; s_valid = 1'b0; s_data_l = '0; s_data_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_out", sd_out, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_count", underrun_count, 0);
    rst = 1'b0;

    // Pair loaded before the first real left start
    send_pair(8'hA5, 8'h3C);
    check("ready_low_after_accept", s_ready, 0);
    wait_pos(40);
    push_exp(8'hA5, 8'h3C, 1, 0, 0);
    wait_pos(0);
    repeat (4) @(posedge clk);
    #1 check("ready_back_at_left_start", s_ready, 1);
    frame(1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0, 0);

    // Starved frames
    frame(1'b0, '0, '0, c_UR1_L, c_UR1_R, 1, 1);
    frame(1'b0, '0, '0, c_UR1_L, c_UR1_R, 1, 2);
    frame(1'b0, '0, '0, c_UR1_L, c_UR1_R, 1, 3);

    // s_valid held high over four distinct pairs
    wait_pos(40);
    for (int i = 0; i < 4; i++) push_exp(pl[i], pr[i], 1, 0, 3);
    for (int i = 0; i < 4; i++) begin
      s_data_l = pl[i];
      s_data_r = pr[i];
      s_valid  = 1'b1;
      wait_ready();
      wait_pos(50);
      check("ready_low_until_left", s_ready, 0);
    end
    s_valid = 1'b0;

    // Accept on the same clk as an empty left-start boundary
    wait_pos(40);
    push_exp(c_UR2_L, c_UR2_R, 1, 1, 4);
    push_exp(8'h5A, 8'hC3, 1, 0, 4);
    wait_pos(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    s_data_l = 8'h5A; s_data_r = 8'hC3; s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    check("ready_low_after_simul_accept", s_ready, 0);

    // Reset in the middle of a left word
    wait_pos(40);
    send_pair(8'h96, 8'h69);
    wait_pos(40);
    wait_pos(4);
    send_pair(8'h3A, 8'hC5);
    check("ready_low_before_rst", s_ready, 0);
    repeat (5) @(posedge clk);
    #1 check("sd_out_mid_word", sd_out, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sd_out", sd_out, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_count", underrun_count, 0);
    rst = 1'b0;
    send_pair(8'h3A, 8'hC5);
    wait_pos(40);
    push_exp(8'h3A, 8'hC5, 1, 0, 0);

    // Reset released just before a ws fall: that fall only primes
    wait_pos(40);
    push_exp(8'h00, 8'h00, 0, 0, 0);
    wait_pos(63);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Saturation of the (4-bit) underrun counter
    for (int i = 1; i <= 17; i++) frame(1'b0, '0, '0, 8'h00, 8'h00, 1, (i > 15) ? 15 : i);

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
